// File: rtl/demux_route_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demux_route_pkg
// Purpose  : Shared types and constants for the demux route controller:
//            FSM state encoding, the tagged route word and a lane decoder.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package demux_route_pkg;

  localparam int NUM_LANES    = 8;
  localparam int DEST_W       = 3;
  localparam int ROUTE_DATA_W = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } route_state_t;

  // Tagged word at the reference payload width; the FIFO packs the same
  // {dest, data} layout at whatever DATA_W the controller is built with.
  typedef struct packed {
    logic [DEST_W-1:0]       dest;
    logic [ROUTE_DATA_W-1:0] data;
  } route_word_t;

  // Destination index to one-hot lane-valid vector.
  function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [DEST_W-1:0] dest);
    logic [NUM_LANES-1:0] v;
    v       = '0;
    v[dest] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/demux_route_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : demux_route_ctrl_if
// Purpose  : Bus bundle for the route controller: the producer valid/ready
//            input channel and the demux-facing sel/din/valid/ready channel.
// Ports    : in_valid/in_ready/in_data/in_dest  - producer side
//            demux_sel/demux_din/out_valid/out_ready - demux/consumer side
//            modport master : the controller view (drives in_ready and
//                             the demux channel)
//            modport slave  : the surrounding system view
// Revision : 1.0 - initial release
// ============================================================================
interface demux_route_ctrl_if #(
  parameter int DATA_W = 8
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [2:0]        in_dest;
  logic [2:0]        demux_sel;
  logic [DATA_W-1:0] demux_din;
  logic [7:0]        out_valid;
  logic [7:0]        out_ready;

  modport master (
    input  in_valid, in_data, in_dest, out_ready,
    output in_ready, demux_sel, demux_din, out_valid
  );

  modport slave (
    output in_valid, in_data, in_dest, out_ready,
    input  in_ready, demux_sel, demux_din, out_valid
  );

endinterface
`default_nettype wire

// File: rtl/route_fifo.sv
`default_nettype none
// ============================================================================
// Module   : route_fifo
// Purpose  : Synchronous FIFO of tagged {dest, data} words. Exposes the head
//            entry and the entry behind it so the controller can present the
//            next word on the same edge it retires the current one.
// Ports    : clk, rst_n (async active-low)
//            push, push_dest, push_data     - write side
//            pop                            - retire head
//            head_dest/head_data            - entry at read pointer
//            next_dest/next_data            - entry at read pointer + 1
//            count, full, empty             - occupancy
// Revision : 1.0 - initial release
// ============================================================================
module route_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  wire logic                     clk,
  input  wire logic                     rst_n,
  input  wire logic                     push,
  input  wire logic [2:0]               push_dest,
  input  wire logic [DATA_W-1:0]        push_data,
  input  wire logic                     pop,
  output logic      [2:0]               head_dest,
  output logic      [DATA_W-1:0]        head_data,
  output logic      [2:0]               next_dest,
  output logic      [DATA_W-1:0]        next_data,
  output logic      [$clog2(DEPTH):0]   count,
  output logic                          full,
  output logic                          empty
);

  localparam int                  c_PTR_W  = $clog2(DEPTH);
  localparam int                  c_WORD_W = DATA_W + 3;
  localparam logic [c_PTR_W:0]    c_FULL   = (c_PTR_W+1)'(DEPTH);

  logic [c_WORD_W-1:0] r_mem [DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_PTR_W:0]    r_count;
  logic [c_PTR_W-1:0]  w_rd_nxt;

  // Pointers are power-of-2 wide, so plain increment wraps modulo DEPTH.
  assign w_rd_nxt = r_rd_ptr + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop)  r_rd_ptr <= w_rd_nxt;
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= {push_dest, push_data};
  end

  assign {head_dest, head_data} = r_mem[r_rd_ptr];
  assign {next_dest, next_data} = r_mem[w_rd_nxt];
  assign count = r_count;
  assign full  = (r_count == c_FULL);
  assign empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/demux_route_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : demux_route_ctrl
// Purpose  : Scheduler for the 1:8 demux. Buffers tagged words in a FIFO and
//            presents the head on registered demux_sel/demux_din/out_valid,
//            holding them stable until the addressed lane accepts.
// Ports    : clk, rst_n (async active-low)
//            bus        - demux_route_ctrl_if.master (input + demux channels)
//            fifo_count - FIFO occupancy
//            busy       - FIFO non-empty or a word is being presented
//            drop_cnt   - words dropped by the stall timeout (saturating)
// Config   : `define DEMUX_ROUTE_TIMEOUT_EN drops a head word stalled for
//            TIMEOUT cycles; otherwise the head waits forever, drop_cnt = 0.
// Revision : 1.0 - initial release
// ============================================================================
module demux_route_ctrl
  import demux_route_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  wire logic                   clk,
  input  wire logic                   rst_n,
  demux_route_ctrl_if.master          bus,
  output logic [$clog2(DEPTH):0]      fifo_count,
  output logic                        busy,
  output logic [7:0]                  drop_cnt
);

  localparam int                        c_CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [c_CNT_W-1:0]        c_CNT_ONE = c_CNT_W'(1);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT < 2)) begin : g_param_check
    $error("demux_route_ctrl: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 2");
  end

  route_state_t        r_state, w_state_nxt;
  logic [2:0]          r_sel, w_sel_nxt;
  logic [DATA_W-1:0]   r_din, w_din_nxt;
  logic [7:0]          r_valid, w_valid_nxt;

  logic                w_push, w_pop, w_accept, w_timeout;
  logic                w_full, w_empty;
  logic [c_CNT_W-1:0]  w_count;
  logic [2:0]          w_head_dest, w_next_dest;
  logic [DATA_W-1:0]   w_head_data, w_next_data;

  assign bus.in_ready = !w_full;
  assign w_push       = bus.in_valid && !w_full;
  assign w_accept     = bus.out_ready[r_sel];

  route_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_dest (bus.in_dest),
    .push_data (bus.in_data),
    .pop       (w_pop),
    .head_dest (w_head_dest),
    .head_data (w_head_data),
    .next_dest (w_next_dest),
    .next_data (w_next_data),
    .count     (w_count),
    .full      (w_full),
    .empty     (w_empty)
  );

`ifdef DEMUX_ROUTE_TIMEOUT_EN
  localparam int                   c_STALL_W   = $clog2(TIMEOUT);
  localparam logic [c_STALL_W-1:0] c_STALL_MAX = c_STALL_W'(TIMEOUT - 1);

  logic [c_STALL_W-1:0] r_stall;
  logic [7:0]           r_drop_cnt;

  assign w_timeout = (r_state == SEND) && !w_accept && (r_stall == c_STALL_MAX);

  // Counts consecutive unaccepted cycles of the current head; any retire
  // (handshake or drop) starts the next head from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall    <= '0;
      r_drop_cnt <= 8'h00;
    end else begin
      if ((r_state == SEND) && !w_accept && !w_timeout) r_stall <= r_stall + 1'b1;
      else                                              r_stall <= '0;
      if (w_timeout && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`else
  assign w_timeout = 1'b0;
  assign drop_cnt  = 8'h00;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sel   <= 3'd0;
      r_din   <= '0;
      r_valid <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_din   <= w_din_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_din_nxt   = r_din;
    w_valid_nxt = r_valid;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_state_nxt = SEND;
          w_sel_nxt   = w_head_dest;
          w_din_nxt   = w_head_data;
          w_valid_nxt = lane_onehot(w_head_dest);
        end
      end
      SEND: begin
        if (w_accept || w_timeout) begin
          w_pop = 1'b1;
          // The word behind the head is either already stored, or is the one
          // being pushed on this same edge into a single-entry FIFO.
          if (w_count > c_CNT_ONE) begin
            w_sel_nxt   = w_next_dest;
            w_din_nxt   = w_next_data;
            w_valid_nxt = lane_onehot(w_next_dest);
          end else if (w_push) begin
            w_sel_nxt   = bus.in_dest;
            w_din_nxt   = bus.in_data;
            w_valid_nxt = lane_onehot(bus.in_dest);
          end else begin
            w_state_nxt = IDLE;
            w_valid_nxt = 8'h00;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_valid_nxt = 8'h00;
      end
    endcase
  end

  assign bus.demux_sel = r_sel;
  assign bus.demux_din = r_din;
  assign bus.out_valid = r_valid;
  assign fifo_count    = w_count;
  assign busy          = (w_count != '0) || (r_state == SEND);

endmodule
`default_nettype wire
